spi_regbank_peripheral: RTL and testbench

Parametrised SPI mode-0 target that replaces the fixed five-register write-only peripheral in the control path. It oversamples `ncs`/`sclk`/`copi` in the `clk` domain and decodes write and read frames. Writes commit atomically to a bank of `NUM_REGS` registers only after a frame of exactly the correct length completes. Reads shift the addressed register back on `cipo`. Unaddressed registers always hold their value.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync.sv | 37 +++
 rtl/spi_regbank_peripheral.sv | 168 ++++++++++++++++
 tb/tb_spi_regbank_peripheral.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-bank target.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        OVER
    } state_t;

    // Mode 0 only: sclk idles low, data sampled on the rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // One R/W bit, then the address field, then the data field.
    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Synchroniser chain for one asynchronous SPI pin plus registered edge pulses.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   level_p1;

    // Metastability chain; resets low so a pin already low at reset release makes no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_q <= '0;
        else        chain_q <= {chain_q[SYNC_STAGES-2:0], din};
    end

    assign level = chain_q[SYNC_STAGES-1];

    // Registered edge detector: one-cycle pulses one clk after the level changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_p1 <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            level_p1 <= level;
            rise     <= level & ~level_p1;
            fall     <= ~level & level_p1;
        end
    end

endmodule

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 target with an atomically written, readable register bank.
module spi_regbank_peripheral
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ncs,
    input  logic                         sclk,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_OVER     = CNT_W'(FRAME_LEN + 1);

    logic ncs_rise, ncs_fall, sclk_rise, sclk_fall, copi_q;
    logic ncs_unused_level, sclk_unused_level, copi_unused_rise, copi_unused_fall;
    logic sample_edge, drive_edge;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .level(ncs_unused_level), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_unused_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .level(copi_q), .rise(copi_unused_rise), .fall(copi_unused_fall)
    );

    assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
    assign drive_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt, cnt_inc;
    logic [FRAME_LEN-1:0]     shift_in, shift_nxt;
    logic [DATA_W-1:0]        rd_shift, rd_val;
    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]      wr_sel;
    logic                     rd_active, wr_ok, bad_len;
    logic                     sample_en, addr_done, over_entry, drive_en;

    assign cnt_inc   = bit_cnt + CNT_W'(1);
    assign shift_nxt = {shift_in[FRAME_LEN-2:0], copi_q};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; an ncs rise always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (ncs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (ncs_fall) state_d = CMD;
                CMD:     if (sample_edge) state_d = ADDR;
                ADDR:    if (sample_edge && cnt_inc == CNT_ADDR_END) state_d = DATA;
                DATA:    if (sample_edge && cnt_inc == CNT_OVER) state_d = OVER;
                default: state_d = state_q;
            endcase
        end
    end

    // Per-state strobes that steer the shifters and the cipo driver.
    always_comb begin
        sample_en  = sample_edge && (state_q == CMD || state_q == ADDR || state_q == DATA);
        addr_done  = sample_en && state_q == ADDR && cnt_inc == CNT_ADDR_END;
        over_entry = sample_en && state_q == DATA && cnt_inc == CNT_OVER;
        drive_en   = drive_edge && state_q == DATA && rd_active && bit_cnt < CNT_FRAME;
    end

    // Bit counter: cleared on either ncs edge, frozen (saturated) once in OVER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      bit_cnt <= '0;
        else if (ncs_rise || ncs_fall)   bit_cnt <= '0;
        else if (sample_en)              bit_cnt <= cnt_inc;
    end

    // Incoming frame shifter; only control state needs reset.
    always_ff @(posedge clk) begin
        if (sample_en) shift_in <= shift_nxt;
    end

    // Address decode for the commit path and the read-back path.
    always_comb begin
        wr_sel = '0;
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (shift_in[DATA_W +: ADDR_W] == ADDR_W'(k)) wr_sel[k] = 1'b1;
            if (shift_nxt[ADDR_W-1:0] == ADDR_W'(k))      rd_val = regs_q[k];
        end
        wr_ok   = shift_in[FRAME_LEN-1] && bit_cnt == CNT_FRAME && (|wr_sel);
        bad_len = bit_cnt != '0 && bit_cnt != CNT_FRAME;
    end

    // Commit on ncs rise: write the addressed register or flag a bad-length frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= '0;
            frame_err <= 1'b0;
            if (ncs_rise) begin
                if (bad_len) begin
                    frame_err <= 1'b1;
                end else if (wr_ok) begin
                    wr_strobe <= wr_sel;
                    for (int k = 0; k < NUM_REGS; k++)
                        if (wr_sel[k]) regs_q[k] <= shift_in[DATA_W-1:0];
                end
            end
        end
    end

    // Read data shifter: loaded when the address completes, shifted per drive edge.
    always_ff @(posedge clk) begin
        if (addr_done)     rd_shift <= rd_val;
        else if (drive_en) rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
    end

    // cipo driver and output enable for the data phase of a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_active <= 1'b0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
        end else if (ncs_rise || ncs_fall) begin
            rd_active <= 1'b0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
        end else begin
            if (addr_done) rd_active <= ~shift_nxt[ADDR_W];
            if (over_entry) begin
                rd_active <= 1'b0;
                cipo      <= 1'b0;
                cipo_oe   <= 1'b0;
            end else if (drive_en) begin
                cipo    <= rd_shift[DATA_W-1];
                cipo_oe <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs[k*DATA_W +: DATA_W] = regs_q[k];
    end

endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// Directed-vector bench for spi_regbank_peripheral with default parameters.
`timescale 1ns/1ps
module tb_spi_regbank_peripheral;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ncs = 1'b1;
    logic        sclk = 1'b0;
    logic        copi = 1'b0;
    logic        cipo, cipo_oe, frame_err;
    logic [39:0] regs;
    logic [4:0]  wr_strobe;

    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          strobe_pulses = 0;
    int          err_pulses = 0;
    logic [4:0]  last_strobe = '0;
    logic [39:0] regs_at_strobe = '0;

    spi_regbank_peripheral dut (
        .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs),
        .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_strobe != 5'b0) begin
            strobe_pulses  = strobe_pulses + 1;
            last_strobe    = wr_strobe;
            regs_at_strobe = regs;
        end
        if (frame_err) err_pulses = err_pulses + 1;
    end

    task automatic spi_start();
        ncs = 1'b0;
        #(HALF);
    endtask

    task automatic spi_bits(input logic [31:0] data, input int n,
                            output logic [31:0] rx, output logic [31:0] oe);
        rx = '0;
        oe = '0;
        for (int i = n - 1; i >= 0; i--) begin
            copi = data[i];
            #(HALF);
            sclk = 1'b1;
            #(HALF/2);
            rx = {rx[30:0], cipo};
            oe = {oe[30:0], cipo_oe};
            #(HALF/2);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        #(HALF);
        ncs = 1'b1;
        #(HALF*2);
    endtask

    task automatic spi_frame(input logic [31:0] data, input int n,
                             output logic [31:0] rx, output logic [31:0] oe);
        spi_start();
        spi_bits(data, n, rx, oe);
        spi_end();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (regs !== 40'h0) begin miss_cnt++; $display("FAIL reset_regs: got %h want %h", regs, 40'h0); end
        vec_cnt++; if (wr_strobe !== 5'b0) begin miss_cnt++; $display("FAIL reset_strobe: got %b want 00000", wr_strobe); end
        vec_cnt++; if (frame_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_err: got %b want 0", frame_err); end
        vec_cnt++; if (cipo !== 1'b0) begin miss_cnt++; $display("FAIL reset_cipo: got %b want 0", cipo); end
        vec_cnt++; if (cipo_oe !== 1'b0) begin miss_cnt++; $display("FAIL reset_oe: got %b want 0", cipo_oe); end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vec_cnt++; if (err_pulses !== 0 || strobe_pulses !== 0) begin miss_cnt++; $display("FAIL post_reset_pulses: got err=%0d strobe=%0d want 0/0", err_pulses, strobe_pulses); end
    endtask

    task automatic test_write_basic();
        logic [31:0] rx, oe;
        int s0, e0;
        s0 = strobe_pulses; e0 = err_pulses;
        spi_frame(32'h82A5, 16, rx, oe);
        vec_cnt++; if (regs !== 40'h0000A50000) begin miss_cnt++; $display("FAIL write2_regs: got %h want %h", regs, 40'h0000A50000); end
        vec_cnt++; if (strobe_pulses - s0 !== 1) begin miss_cnt++; $display("FAIL write2_strobe_cycles: got %0d want 1", strobe_pulses - s0); end
        vec_cnt++; if (last_strobe !== 5'b00100) begin miss_cnt++; $display("FAIL write2_strobe_bit: got %b want 00100", last_strobe); end
        vec_cnt++; if (regs_at_strobe[23:16] !== 8'hA5) begin miss_cnt++; $display("FAIL write2_same_cycle: got %h want a5", regs_at_strobe[23:16]); end
        vec_cnt++; if (err_pulses - e0 !== 0) begin miss_cnt++; $display("FAIL write2_err: got %0d want 0", err_pulses - e0); end
        vec_cnt++; if (oe[15:0] !== 16'h0000) begin miss_cnt++; $display("FAIL write2_oe: got %h want 0000", oe[15:0]); end
    endtask

    task automatic test_write_two();
        logic [31:0] rx, oe;
        int s0;
        s0 = strobe_pulses;
        spi_frame(32'h803C, 16, rx, oe);
        vec_cnt++; if (last_strobe !== 5'b00001) begin miss_cnt++; $display("FAIL write0_strobe_bit: got %b want 00001", last_strobe); end
        spi_frame(32'h8481, 16, rx, oe);
        vec_cnt++; if (regs !== 40'h8100A5003C) begin miss_cnt++; $display("FAIL write04_regs: got %h want %h", regs, 40'h8100A5003C); end
        vec_cnt++; if (last_strobe !== 5'b10000) begin miss_cnt++; $display("FAIL write4_strobe_bit: got %b want 10000", last_strobe); end
        vec_cnt++; if (strobe_pulses - s0 !== 2) begin miss_cnt++; $display("FAIL write04_strobes: got %0d want 2", strobe_pulses - s0); end
    endtask

    task automatic test_read();
        logic [31:0] rx, oe;
        int s0;
        s0 = strobe_pulses;
        spi_frame(32'h0200, 16, rx, oe);
        vec_cnt++; if (rx[15:0] !== 16'h00A5) begin miss_cnt++; $display("FAIL read2_data: got %h want 00a5", rx[15:0]); end
        vec_cnt++; if (oe[15:0] !== 16'h00FF) begin miss_cnt++; $display("FAIL read2_oe: got %h want 00ff", oe[15:0]); end
        vec_cnt++; if (cipo_oe !== 1'b0) begin miss_cnt++; $display("FAIL read2_oe_after: got %b want 0", cipo_oe); end
        vec_cnt++; if (regs !== 40'h8100A5003C) begin miss_cnt++; $display("FAIL read2_bank: got %h want %h", regs, 40'h8100A5003C); end
        vec_cnt++; if (strobe_pulses - s0 !== 0) begin miss_cnt++; $display("FAIL read2_strobe: got %0d want 0", strobe_pulses - s0); end
    endtask

    task automatic test_frame_errors();
        logic [31:0] rx, oe;
        int s0, e0;
        s0 = strobe_pulses; e0 = err_pulses;
        spi_frame(32'h0207, 10, rx, oe);
        vec_cnt++; if (err_pulses - e0 !== 1) begin miss_cnt++; $display("FAIL short_err: got %0d want 1", err_pulses - e0); end
        spi_frame(32'h103FF, 17, rx, oe);
        vec_cnt++; if (err_pulses - e0 !== 2) begin miss_cnt++; $display("FAIL long_err: got %0d want 2", err_pulses - e0); end
        spi_start();
        spi_end();
        vec_cnt++; if (err_pulses - e0 !== 2) begin miss_cnt++; $display("FAIL empty_frame_err: got %0d want 2", err_pulses - e0); end
        vec_cnt++; if (strobe_pulses - s0 !== 0) begin miss_cnt++; $display("FAIL errframe_strobe: got %0d want 0", strobe_pulses - s0); end
        vec_cnt++; if (regs !== 40'h8100A5003C) begin miss_cnt++; $display("FAIL errframe_bank: got %h want %h", regs, 40'h8100A5003C); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rx, oe;
        int s0, e0;
        s0 = strobe_pulses; e0 = err_pulses;
        spi_frame(32'hE4FF, 16, rx, oe);
        vec_cnt++; if (strobe_pulses - s0 !== 0 || err_pulses - e0 !== 0) begin miss_cnt++; $display("FAIL oor_write_pulses: got strobe=%0d err=%0d want 0/0", strobe_pulses - s0, err_pulses - e0); end
        vec_cnt++; if (regs !== 40'h8100A5003C) begin miss_cnt++; $display("FAIL oor_write_bank: got %h want %h", regs, 40'h8100A5003C); end
        spi_frame(32'h6400, 16, rx, oe);
        vec_cnt++; if (rx[7:0] !== 8'h00) begin miss_cnt++; $display("FAIL oor_read_data: got %h want 00", rx[7:0]); end
        vec_cnt++; if (oe[15:0] !== 16'h00FF) begin miss_cnt++; $display("FAIL oor_read_oe: got %h want 00ff", oe[15:0]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rx, oe;
        int s0, e0;
        spi_start();
        spi_bits(32'h815, 12, rx, oe);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (regs !== 40'h0 || wr_strobe !== 5'b0 || frame_err !== 1'b0 || cipo !== 1'b0 || cipo_oe !== 1'b0) begin
            miss_cnt++; $display("FAIL midreset_outputs: got regs=%h strobe=%b err=%b cipo=%b oe=%b want all 0", regs, wr_strobe, frame_err, cipo, cipo_oe);
        end
        rst_n = 1'b1;
        s0 = strobe_pulses; e0 = err_pulses;
        spi_bits(32'hA, 4, rx, oe);
        spi_end();
        vec_cnt++; if (strobe_pulses - s0 !== 0 || err_pulses - e0 !== 0) begin miss_cnt++; $display("FAIL midreset_tail_pulses: got strobe=%0d err=%0d want 0/0", strobe_pulses - s0, err_pulses - e0); end
        vec_cnt++; if (regs !== 40'h0) begin miss_cnt++; $display("FAIL midreset_tail_bank: got %h want 0", regs); end
        spi_frame(32'h815A, 16, rx, oe);
        vec_cnt++; if (regs !== 40'h0000005A00) begin miss_cnt++; $display("FAIL midreset_rewrite: got %h want %h", regs, 40'h0000005A00); end
        vec_cnt++; if (last_strobe !== 5'b00010) begin miss_cnt++; $display("FAIL midreset_strobe: got %b want 00010", last_strobe); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rx, oe;
        spi_frame(32'h833C, 16, rx, oe);
        spi_frame(32'h0300, 16, rx, oe);
        vec_cnt++; if (rx[7:0] !== 8'h3C) begin miss_cnt++; $display("FAIL b2b_read3: got %h want 3c", rx[7:0]); end
        vec_cnt++; if (regs !== 40'h003C005A00) begin miss_cnt++; $display("FAIL b2b_bank: got %h want %h", regs, 40'h003C005A00); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_two();
        test_read();
        test_frame_errors();
        test_out_of_range();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
